fetch_unit: RTL

Instruction-fetch stage of the 8-bit core. It sits directly upstream of `instruction_memory`, supplying `pc_address` and consuming `out_instruction`. It registers each fetched word with its PC into an IF/ID output register and hands it to decode over a valid/ready handshake. It also handles branch redirects, with a flush, and a terminal halt.

---
 rtl/cpu_pkg.sv | 7 +
 rtl/program_counter.sv | 19 +
 rtl/fetch_unit.sv | 64 ++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: widths, halt encoding and fetch state shared across pipeline stages
package cpu_pkg;
   localparam int ADDR_WIDTH = 8;
   localparam int INSTR_WIDTH = 8;
   localparam logic [INSTR_WIDTH-1:0] HALT_INSTR = 8'hFF;
   typedef enum logic {FETCH, HALTED} fetch_state_t;
endpackage

// File: rtl/program_counter.sv
// program_counter: PC register with reset, even-forced load, step increment and hold
module program_counter #(
   parameter int ADDR_WIDTH = 8,
   parameter int PC_STEP = 2,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load_i,
   input  logic [ADDR_WIDTH-1:0] target_i,
   input  logic                  inc_i,
   output logic [ADDR_WIDTH-1:0] pc_o
);
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   // Slots are 2-byte aligned, so the low target bit is cleared on load
   always_comb pc_d = load_i ? (target_i & ~ADDR_WIDTH'(1)) : inc_i ? pc_q + ADDR_WIDTH'(PC_STEP) : pc_q;
   always_ff @(posedge clk) pc_q <= reset ? RESET_PC : pc_d;
   assign pc_o = pc_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch with IF/ID register, valid/ready handoff, branch flush and halt
module fetch_unit #(
   parameter int ADDR_WIDTH = cpu_pkg::ADDR_WIDTH,
   parameter int INSTR_WIDTH = cpu_pkg::INSTR_WIDTH,
   parameter int PC_STEP = 2,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
   parameter logic [INSTR_WIDTH-1:0] HALT_INSTR = cpu_pkg::HALT_INSTR
) (
   input  logic                   clk,
   input  logic                   reset,
   output logic [ADDR_WIDTH-1:0]  pc_address,
   input  logic [INSTR_WIDTH-1:0] mem_instruction,
   input  logic                   branch_valid,
   input  logic [ADDR_WIDTH-1:0]  branch_target,
   input  logic                   id_ready,
   output logic                   if_valid,
   output logic [INSTR_WIDTH-1:0] if_instruction,
   output logic [ADDR_WIDTH-1:0]  if_pc,
   output logic                   halted
);
   import cpu_pkg::fetch_state_t;
   import cpu_pkg::FETCH;
   import cpu_pkg::HALTED;
   fetch_state_t state_q;
   logic valid_q, halted_q;
   logic [INSTR_WIDTH-1:0] instr_q;
   logic [ADDR_WIDTH-1:0] ifpc_q;
   logic fetching, adv, is_halt;
   assign fetching = state_q == FETCH;
   assign adv = !valid_q || id_ready;
   assign is_halt = mem_instruction == HALT_INSTR;
   program_counter #(.ADDR_WIDTH(ADDR_WIDTH), .PC_STEP(PC_STEP), .RESET_PC(RESET_PC)) u_pc (
      .clk(clk),
      .reset(reset),
      .load_i(fetching && branch_valid),
      .target_i(branch_target),
      .inc_i(fetching && !branch_valid && adv && !is_halt),
      .pc_o(pc_address)
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FETCH;
         valid_q <= 1'b0;
         instr_q <= '0;
         ifpc_q <= '0;
         halted_q <= 1'b0;
      end else if (fetching) begin
         if (branch_valid) valid_q <= 1'b0;
         else if (adv) begin
            instr_q <= mem_instruction;
            ifpc_q <= pc_address;
            valid_q <= 1'b1;
            if (is_halt) begin
               state_q <= HALTED;
               halted_q <= 1'b1;
            end
         end
      end else if (id_ready) valid_q <= 1'b0;
   end
   assign if_valid = valid_q;
   assign if_instruction = instr_q;
   assign if_pc = ifpc_q;
   assign halted = halted_q;
endmodule
